mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
- Parametrised successor to the 2:1 select primitive: NUM_IN-way, WIDTH-bit multiplexer with a registered output stage and valid/ready handshaking on every port.
- Two select modes: explicit (external sel) or round-robin (internal fair arbitration among valid inputs).
- Used to steer operands, writeback sources or memory requesters onto one shared bus in the pipelined processor.

Parameters:
- WIDTH, 16, data bits per input/output.
- NUM_IN, 4, number of inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input i at bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-input valid.
- in_ready  output  NUM_IN  per-input ready (combinational).
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SEL_W  explicit select index (mode 0 only).
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SEL_W  index of the input held in out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=NUM_IN-1 (so input 0 has first priority). Reset overrides any transfer in the same cycle; a held, unaccepted word is dropped.
- load_en = !out_valid || out_ready (single-entry register, full throughput, 1-cycle latency input->output).
- Grant g (combinational):
  - mode 0: g = sel if sel < NUM_IN, else no grant.
  - mode 1: first i with in_valid[i]=1 scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN; no grant if none valid.
- in_ready[i] = load_en && grant exists && i==g; all others 0. In mode 0, in_ready[sel] may be 1 while in_valid[sel]=0.
- Transfer on input g when in_valid[g] && in_ready[g]: next cycle out_data=in_data[g], out_sel=g, out_valid=1; in mode 1 rr_ptr<=g.
- No transfer and out_ready=1: out_valid<=0; out_data/out_sel hold their last value.
- out_valid=1 and out_ready=0: out_data, out_valid and out_sel hold; all in_ready=0.
- Simultaneous accept and load: the new word replaces the old word in the same edge, with no bubble.
- rr_ptr changes only on mode-1 transfers. Mode or sel changes never disturb a held word and take effect on the next grant.
- Wrap-around: with rr_ptr=NUM_IN-1, the scan starts at input 0.

Optional Feature:
- Macro MUX_ARB_N_STATS_EN.
- Defined: adds output port xfer_cnt [NUM_IN*16], one 16-bit counter per input. A counter increments on each transfer from its input, saturates at 16'hFFFF and clears on rst.
- Undefined: the port and counters are absent, with no other change to behaviour.

Decomposition:
- Package mux_arb_pkg: MODE_EXPLICIT=1'b0, MODE_RR=1'b1, CNT_W=16, and a function for the SEL_W range check.
- Sub-module rr_pick (inputs: NUM_IN-bit request vector and pointer; outputs: grant_idx and grant_vld) holds the rotate/priority logic. The top level holds the register, handshake and counters.

Test Plan:
- Reset: assert rst with out_valid=1 held -> next cycle out_valid=0, out_data=0, out_sel=0, rr_ptr=3.
- Explicit: mode=0, sel=2, in_valid=4'b1111, in_data[2]=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=16'hBEEF, out_sel=2, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles with a word held -> in_ready=0 and out_data unchanged; on out_ready=1, the new word loads the same edge.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3.
- RR skip/wrap: mode=1, in_valid=4'b1001, rr_ptr=0 -> grant 3, then 0, then 3.
- Out-of-range select: NUM_IN=3, SEL_W=2, sel=3 -> in_ready=0 and out_valid drops after the held word drains. With MUX_ARB_N_STATS_EN defined, drive 70000 transfers on input 1 -> xfer_cnt[1]=16'hFFFF.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// mux_arb_pkg: shared constants and the select-width range check for mux_arb_n.
package mux_arb_pkg;
    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_RR = 1'b1;
    localparam int CNT_W = 16;
    function automatic bit sel_w_ok(int num_in, int sel_w);
        return (1 << sel_w) >= num_in;
    endfunction
endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: input/output handshake bundle; MUX_ARB_N_STATS_EN adds xfer_cnt.
interface mux_arb_n_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0] in_valid;
    logic [NUM_IN-1:0] in_ready;
    logic mode;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] out_data;
    logic out_valid;
    logic [SEL_W-1:0] out_sel;
    logic out_ready;
`ifdef MUX_ARB_N_STATS_EN
    logic [NUM_IN*CNT_W-1:0] xfer_cnt;
    modport master (output in_data, in_valid, mode, sel, out_ready,
                    input in_ready, out_data, out_valid, out_sel, xfer_cnt);
    modport slave (input in_data, in_valid, mode, sel, out_ready,
                   output in_ready, out_data, out_valid, out_sel, xfer_cnt);
`else
    modport master (output in_data, in_valid, mode, sel, out_ready,
                    input in_ready, out_data, out_valid, out_sel);
    modport slave (input in_data, in_valid, mode, sel, out_ready,
                   output in_ready, out_data, out_valid, out_sel);
`endif
endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: first requester after ptr, scanning upward modulo NUM_IN.
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int SEL_W = 2
) (
    input logic [NUM_IN-1:0] req,
    input logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic grant_vld
);
    int best;
    int d;
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        best = NUM_IN;
        d = 0;
        // distance from ptr+1 going forward; ptr never exceeds NUM_IN-1 so the sum stays non-negative
        for (int i = 0; i < NUM_IN; i++) begin
            d = (i + NUM_IN - 1 - int'(ptr)) % NUM_IN;
            if (req[i] && d < best) begin
                best = d;
                grant_idx = SEL_W'(i);
                grant_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: NUM_IN-way registered mux with explicit or round-robin select.
// Optional per-input transfer counters under MUX_ARB_N_STATS_EN.
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W = 2
) (
    input logic clk,
    input logic rst,
    mux_arb_n_if.slave bus
);
    if (!sel_w_ok(NUM_IN, SEL_W)) begin : g_bad_sel_w
        $error("mux_arb_n: SEL_W too small for NUM_IN");
    end
    logic [WIDTH-1:0] lanes [NUM_IN];
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q, rr_ptr, rr_idx, g;
    logic valid_q, rr_vld, g_vld, load_en, xfer;
    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        assign lanes[i] = bus.in_data[i*WIDTH +: WIDTH];
    end
    rr_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_pick (
        .req(bus.in_valid),
        .ptr(rr_ptr),
        .grant_idx(rr_idx),
        .grant_vld(rr_vld)
    );
    always_comb begin
        load_en = !valid_q || bus.out_ready;
        g = bus.mode == MODE_RR ? rr_idx : bus.sel;
        g_vld = bus.mode == MODE_RR ? rr_vld : int'(bus.sel) < NUM_IN;
        bus.in_ready = (load_en && g_vld) ? NUM_IN'(1) << g : '0;
        xfer = |(bus.in_ready & bus.in_valid);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q <= '0;
            sel_q <= '0;
            rr_ptr <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q <= lanes[g];
            sel_q <= g;
            if (bus.mode == MODE_RR) rr_ptr <= g;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
    assign bus.out_data = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sel = sel_q;
`ifdef MUX_ARB_N_STATS_EN
    for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) cnt <= '0;
            else if (bus.in_ready[i] && bus.in_valid[i] && cnt != '1) cnt <= cnt + 1'b1;
        end
        assign bus.xfer_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif
endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed vector table plus reset, out-of-range select and counter sequences.
module tb_mux_arb_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    mux_arb_n_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) b4 ();
    mux_arb_n_if #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) b3 ();
    mux_arb_n #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mux_arb_n #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    typedef struct {
        logic mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic rdy;
        logic [3:0] exp_rdy;
        logic exp_ov;
        logic [1:0] exp_sel;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        b4.mode = m;
        b4.sel = s;
        b4.in_valid = v;
        b4.out_ready = r;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
        vecs[1]  = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
        vecs[2]  = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
        vecs[3]  = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
        vecs[4]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hA001};
        vecs[5]  = '{1'b0, 2'd0, 4'b1110, 1'b1, 4'b0001, 1'b0, 2'd1, 16'hA001};
        vecs[6]  = '{1'b0, 2'd0, 4'b1110, 1'b0, 4'b0001, 1'b0, 2'd1, 16'hA001};
        vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hA001};
        vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
        vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hA003};
        vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hA001};
        vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
        vecs[14] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hA003};
        vecs[15] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        vecs[16] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hA003};
        vecs[17] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 16'hA000};
        vecs[18] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hA003};
        vecs[19] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 16'hA003};
        vecs[20] = '{1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'hBEEF};
        vecs[21] = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'hBEEF};
        vecs[22] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'hA003};

        b4.in_data = {16'hA003, 16'hBEEF, 16'hA001, 16'hA000};
        drive4(1'b0, 2'd0, 4'b0000, 1'b0);
        b3.in_data = {16'hB002, 16'hB001, 16'hB000};
        b3.mode = 1'b0;
        b3.sel = 2'd0;
        b3.in_valid = 3'b000;
        b3.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ov", 32'(b4.out_valid), 32'd0);
        chk("reset_data", 32'(b4.out_data), 32'd0);
        chk("reset_sel", 32'(b4.out_sel), 32'd0);

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive4(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(b4.in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(b4.out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("v%0d_out_sel", i), 32'(b4.out_sel), 32'(vecs[i].exp_sel));
            chk($sformatf("v%0d_out_data", i), 32'(b4.out_data), 32'(vecs[i].exp_data));
        end

        // reset drops a held, unaccepted word and restores input 0 priority
        @(negedge clk);
        drive4(1'b0, 2'd2, 4'b1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_held_ov", 32'(b4.out_valid), 32'd0);
        chk("rst_held_data", 32'(b4.out_data), 32'd0);
        chk("rst_held_sel", 32'(b4.out_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive4(1'b1, 2'd0, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_ptr_sel", 32'(b4.out_sel), 32'd0);
        chk("rst_ptr_data", 32'(b4.out_data), 32'hA000);

        // out-of-range explicit select on the 3-input instance
        @(negedge clk);
        b3.sel = 2'd1;
        b3.in_valid = 3'b111;
        b3.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("n3_load_sel", 32'(b3.out_sel), 32'd1);
        chk("n3_load_data", 32'(b3.out_data), 32'hB001);
        @(negedge clk);
        b3.sel = 2'd3;
        b3.out_ready = 1'b0;
        #1;
        chk("n3_oor_ready_held", 32'(b3.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_oor_hold_ov", 32'(b3.out_valid), 32'd1);
        @(negedge clk);
        b3.out_ready = 1'b1;
        #1;
        chk("n3_oor_ready_drain", 32'(b3.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_oor_drain_ov", 32'(b3.out_valid), 32'd0);
        chk("n3_oor_drain_data", 32'(b3.out_data), 32'hB001);

`ifdef MUX_ARB_N_STATS_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive4(1'b0, 2'd1, 4'b1111, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt1_three", 32'(b4.xfer_cnt[16 +: 16]), 32'd3);
        repeat (65540) @(posedge clk);
        #1;
        chk("cnt1_sat", 32'(b4.xfer_cnt[16 +: 16]), 32'hFFFF);
        chk("cnt0_zero", 32'(b4.xfer_cnt[0 +: 16]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
